// File: rtl/lvds_pkg.sv
// Shared command codes, request bit indices and interrupt FSM encoding
// for the LVDS command controller.
package lvds_pkg;

  localparam int unsigned CMD_W = 4;
  localparam int unsigned REQ_W = 9;

  localparam logic [CMD_W-1:0] CMD_PREFILL  = 4'hA;
  localparam logic [CMD_W-1:0] CMD_UP       = 4'h1;
  localparam logic [CMD_W-1:0] CMD_DOWN     = 4'h2;
  localparam logic [CMD_W-1:0] CMD_SHK_UP   = 4'h3;
  localparam logic [CMD_W-1:0] CMD_PRINT    = 4'h4;
  localparam logic [CMD_W-1:0] CMD_SHK_DOWN = 4'h5;
  localparam logic [CMD_W-1:0] CMD_SHK_PASS = 4'h6;
  localparam logic [CMD_W-1:0] CMD_SHK_BOT  = 4'h9;
  localparam logic [CMD_W-1:0] CMD_PASS_END = 4'hE;

  localparam int unsigned REQ_PREFILL  = 0;
  localparam int unsigned REQ_UP       = 1;
  localparam int unsigned REQ_DOWN     = 2;
  localparam int unsigned REQ_SHK_UP   = 3;
  localparam int unsigned REQ_PRINT    = 4;
  localparam int unsigned REQ_SHK_DOWN = 5;
  localparam int unsigned REQ_SHK_PASS = 6;
  localparam int unsigned REQ_SHK_BOT  = 7;
  localparam int unsigned REQ_PASS_END = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } int_state_e;

  // One-hot request for a command code; all-zero means unknown code.
  function automatic logic [REQ_W-1:0] decode_cmd(input logic [CMD_W-1:0] cmd);
    logic [REQ_W-1:0] r;
    r = '0;
    case (cmd)
      CMD_PREFILL:  r[REQ_PREFILL]  = 1'b1;
      CMD_UP:       r[REQ_UP]       = 1'b1;
      CMD_DOWN:     r[REQ_DOWN]     = 1'b1;
      CMD_SHK_UP:   r[REQ_SHK_UP]   = 1'b1;
      CMD_PRINT:    r[REQ_PRINT]    = 1'b1;
      CMD_SHK_DOWN: r[REQ_SHK_DOWN] = 1'b1;
      CMD_SHK_PASS: r[REQ_SHK_PASS] = 1'b1;
      CMD_SHK_BOT:  r[REQ_SHK_BOT]  = 1'b1;
      CMD_PASS_END: r[REQ_PASS_END] = 1'b1;
      default:      r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_bus.sv
// Multi-stage flop chain used both as a synchronizer for control inputs
// and as a matching delay line for the lane data.
module sync_bus #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stg_q [STAGES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(STAGES); i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign q_o = stg_q[STAGES-1];

endmodule

// File: rtl/lvds_cmd_ctrl.sv
// LVDS lane capture, fire-command decode, fire-period statistics and
// pass-end interrupt generation.
module lvds_cmd_ctrl
  import lvds_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned CYC_W    = 16,
  parameter int unsigned INT_LEN  = 100,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH*DATA_W-1:0] prn_data,
  input  logic                     d_sck,
  input  logic                     fire,
  input  logic [3:0]               f_cmd,
  input  logic                     clr_stats,
  output logic                     lvds_valid,
  output logic [NUM_CH*DATA_W-1:0] lvds_data,
  output logic [8:0]               req,
  output logic                     cmd_err,
  output logic [CYC_W-1:0]         fire_cnt,
  output logic [CYC_W-1:0]         cyc_min,
  output logic [CYC_W-1:0]         cyc_max,
  output logic                     int_n,
  output logic                     int_ovr,
  output logic                     data_switch
);

  localparam int unsigned BUS_W     = NUM_CH * DATA_W;
  localparam int unsigned CTRL_W    = CMD_W + 2;
  localparam int unsigned INT_CNT_W = 8;

  logic [CTRL_W-1:0] ctrl_s;
  logic [BUS_W-1:0]  data_s;
  logic              sck_s, fire_s;
  logic [CMD_W-1:0]  cmd_s;

  sync_bus #(.WIDTH(CTRL_W), .STAGES(SYNC_STG)) u_sync_ctrl (
    .clk (clk), .rstn (rstn), .d_i ({f_cmd, fire, d_sck}), .q_o (ctrl_s)
  );

  sync_bus #(.WIDTH(BUS_W), .STAGES(SYNC_STG)) u_sync_data (
    .clk (clk), .rstn (rstn), .d_i (prn_data), .q_o (data_s)
  );

  assign sck_s  = ctrl_s[0];
  assign fire_s = ctrl_s[1];
  assign cmd_s  = ctrl_s[CTRL_W-1:2];

  // Registered edge detection; data and command travel alongside the edge.
  logic             sck_prev_q, fire_prev_q, sck_fall_q, fire_evt_q;
  logic [BUS_W-1:0] data_hold_q;
  logic [CMD_W-1:0] cmd_evt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_prev_q  <= 1'b0;
      fire_prev_q <= 1'b0;
      sck_fall_q  <= 1'b0;
      fire_evt_q  <= 1'b0;
      data_hold_q <= '0;
      cmd_evt_q   <= '0;
    end else begin
      sck_prev_q  <= sck_s;
      fire_prev_q <= fire_s;
      sck_fall_q  <= sck_prev_q & ~sck_s;
      fire_evt_q  <= fire_s & ~fire_prev_q;
      data_hold_q <= data_s;
      cmd_evt_q   <= cmd_s;
    end
  end

  logic             lvds_valid_q, cmd_err_q;
  logic [BUS_W-1:0] lvds_data_q;
  logic [REQ_W-1:0] req_q, dec_c;

  assign dec_c = decode_cmd(cmd_evt_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lvds_valid_q <= 1'b0;
      lvds_data_q  <= '0;
      req_q        <= '0;
      cmd_err_q    <= 1'b0;
    end else begin
      lvds_valid_q <= sck_fall_q;
      if (sck_fall_q) lvds_data_q <= data_hold_q;
      req_q <= fire_evt_q ? dec_c : '0;
      if (clr_stats)                        cmd_err_q <= 1'b0;
      else if (fire_evt_q && dec_c == '0)   cmd_err_q <= 1'b1;
    end
  end

  // Period is cycles between events: counter value plus the event cycle.
  logic [CYC_W-1:0] period_q, cyc_inc_c;
  logic [CYC_W-1:0] stat_min_q, stat_max_q, stat_cnt_q;
  logic [CYC_W-1:0] cyc_min_q, cyc_max_q, fire_cnt_q;
  logic             first_q;

  assign cyc_inc_c = (period_q == '1) ? period_q : period_q + CYC_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      period_q   <= '1;
      stat_min_q <= '1;
      stat_max_q <= '0;
      stat_cnt_q <= '0;
      first_q    <= 1'b0;
      cyc_min_q  <= '1;
      cyc_max_q  <= '0;
      fire_cnt_q <= '0;
    end else begin
      period_q <= fire_evt_q ? '0 : cyc_inc_c;
      if (clr_stats) begin
        stat_min_q <= '1;
        stat_max_q <= '0;
        stat_cnt_q <= '0;
        first_q    <= fire_evt_q;
        cyc_min_q  <= '1;
        cyc_max_q  <= '0;
        fire_cnt_q <= '0;
      end else begin
        if (fire_evt_q) begin
          first_q <= 1'b1;
          if (stat_cnt_q != '1) stat_cnt_q <= stat_cnt_q + CYC_W'(1);
          if (first_q && period_q != '1) begin
            if (cyc_inc_c < stat_min_q) stat_min_q <= cyc_inc_c;
            if (cyc_inc_c > stat_max_q) stat_max_q <= cyc_inc_c;
          end
        end
        cyc_min_q  <= stat_min_q;
        cyc_max_q  <= stat_max_q;
        fire_cnt_q <= stat_cnt_q;
      end
    end
  end

  // Pass-end interrupt: low for INT_LEN cycles, one recovery cycle after.
  int_state_e           state_q, state_d;
  logic [INT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                 ovr_set_c, int_n_q, int_ovr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      int_n_q    <= 1'b1;
      int_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      int_n_q    <= (state_d != ST_WAIT);
      if (clr_stats)      int_ovr_q <= 1'b0;
      else if (ovr_set_c) int_ovr_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ovr_set_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_q[REQ_PASS_END]) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        ovr_set_c = req_q[REQ_PASS_END];
        if (wait_cnt_q == INT_CNT_W'(INT_LEN - 1)) state_d = ST_HOLD;
        else wait_cnt_d = wait_cnt_q + INT_CNT_W'(1);
      end
      ST_HOLD: begin
        ovr_set_c = req_q[REQ_PASS_END];
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign lvds_valid  = lvds_valid_q;
  assign lvds_data   = lvds_data_q;
  assign req         = req_q;
  assign cmd_err     = cmd_err_q;
  assign fire_cnt    = fire_cnt_q;
  assign cyc_min     = cyc_min_q;
  assign cyc_max     = cyc_max_q;
  assign int_n       = int_n_q;
  assign int_ovr     = int_ovr_q;
  assign data_switch = fire_s;

endmodule

// File: tb/tb_lvds_cmd_ctrl.sv
// Directed bench for lvds_cmd_ctrl: data capture, command decode,
// period statistics, interrupt timing, reset and clear priority.
module tb_lvds_cmd_ctrl;
  import lvds_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] prn_data;
  logic        d_sck, fire, clr_stats;
  logic [3:0]  f_cmd;
  logic        lvds_valid, cmd_err, int_n, int_ovr, data_switch;
  logic [31:0] lvds_data;
  logic [8:0]  req;
  logic [15:0] fire_cnt, cyc_min, cyc_max;

  int n_tests = 0;
  int n_fail  = 0;

  lvds_cmd_ctrl dut (
    .clk (clk), .rstn (rstn), .prn_data (prn_data), .d_sck (d_sck),
    .fire (fire), .f_cmd (f_cmd), .clr_stats (clr_stats),
    .lvds_valid (lvds_valid), .lvds_data (lvds_data), .req (req),
    .cmd_err (cmd_err), .fire_cnt (fire_cnt), .cyc_min (cyc_min),
    .cyc_max (cyc_max), .int_n (int_n), .int_ovr (int_ovr),
    .data_switch (data_switch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fire pulse of 3 cycles, then idle so that the next fire starts gap cycles later.
  task automatic fire_gap(input logic [3:0] cmd, input int gap);
    f_cmd = cmd;
    fire  = 1'b1;
    repeat (3) tick();
    fire = 1'b0;
    repeat (gap - 3) tick();
  endtask

  initial begin
    int        first_low;
    int        low_cnt;
    logic [8:0] req_or;

    rstn = 1'b0; prn_data = '0; d_sck = 1'b1; fire = 1'b0;
    f_cmd = 4'h0; clr_stats = 1'b0;
    repeat (3) tick();
    chk("rst_valid",   32'(lvds_valid), 32'h0);
    chk("rst_data",    lvds_data,       32'h0);
    chk("rst_req",     32'(req),        32'h0);
    chk("rst_int_n",   32'(int_n),      32'h1);
    chk("rst_cyc_min", 32'(cyc_min),    32'hFFFF);
    chk("rst_cyc_max", 32'(cyc_max),    32'h0);
    chk("rst_fire_cnt",32'(fire_cnt),   32'h0);
    chk("rst_cmd_err", 32'(cmd_err),    32'h0);
    chk("rst_int_ovr", 32'(int_ovr),    32'h0);
    rstn = 1'b1;
    repeat (5) tick();

    // Lane capture: valid appears SYNC_STG+2 cycles after d_sck falls
    prn_data = 32'h1234ABCD;
    d_sck = 1'b0;
    repeat (3) tick();
    d_sck = 1'b1;
    chk("sck_early", 32'(lvds_valid), 32'h0);
    tick();
    chk("sck_valid", 32'(lvds_valid), 32'h1);
    chk("sck_data",  lvds_data,       32'h1234ABCD);
    tick();
    chk("sck_pulse1", 32'(lvds_valid), 32'h0);
    repeat (6) tick();
    chk("sck_rise_noval", 32'(lvds_valid), 32'h0);
    chk("sck_data_hold",  lvds_data,       32'h1234ABCD);

    prn_data = 32'hDEADBEEF;
    d_sck = 1'b0;
    repeat (3) tick();
    d_sck = 1'b1;
    prn_data = 32'h0;
    tick();
    chk("sck2_valid", 32'(lvds_valid), 32'h1);
    chk("sck2_data",  lvds_data,       32'hDEADBEEF);
    repeat (6) tick();

    // Print command: req[4] at SYNC_STG+1 cycles, one pulse while fire held
    f_cmd = 4'h4;
    fire  = 1'b1;
    tick();
    tick();
    chk("data_switch", 32'(data_switch), 32'h1);
    tick();
    chk("req_early", 32'(req), 32'h0);
    tick();
    chk("req_print", 32'(req), 32'h010);
    chk("req_print_err", 32'(cmd_err), 32'h0);
    req_or = '0;
    repeat (8) begin
      tick();
      req_or = req_or | req;
    end
    chk("req_single", 32'(req_or), 32'h0);
    fire = 1'b0;
    repeat (5) tick();
    chk("data_switch_lo", 32'(data_switch), 32'h0);

    f_cmd = 4'h7;
    fire  = 1'b1;
    req_or = '0;
    repeat (6) begin
      tick();
      req_or = req_or | req;
    end
    chk("req_unknown", 32'(req_or), 32'h0);
    chk("cmd_err_set", 32'(cmd_err), 32'h1);
    fire = 1'b0;
    repeat (5) tick();
    chk("fire_cnt_2", 32'(fire_cnt), 32'h2);

    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    tick();
    chk("clr_cmd_err",  32'(cmd_err),  32'h0);
    chk("clr_fire_cnt", 32'(fire_cnt), 32'h0);

    // Periods 50, 30, 80
    fire_gap(4'h1, 50);
    fire_gap(4'h1, 30);
    fire_gap(4'h1, 80);
    fire_gap(4'h1, 10);
    chk("stat_min", 32'(cyc_min),  32'd30);
    chk("stat_max", 32'(cyc_max),  32'd80);
    chk("stat_cnt", 32'(fire_cnt), 32'd4);

    // Long idle saturates the period counter; next fire does not update stats
    repeat (70000) tick();
    chk("period_sat", 32'(dut.period_q), 32'hFFFF);
    fire_gap(4'h1, 10);
    chk("sat_min", 32'(cyc_min),  32'd30);
    chk("sat_max", 32'(cyc_max),  32'd80);
    chk("sat_cnt", 32'(fire_cnt), 32'd5);

    // Pass-end interrupt with a second pass-end 20 cycles into the low phase
    first_low = -1;
    low_cnt   = 0;
    f_cmd     = 4'hE;
    for (int i = 0; i < 300; i++) begin
      if (i == 0 || i == 24) fire = 1'b1;
      if (i == 3 || i == 27) fire = 1'b0;
      tick();
      if (int_n == 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
      end
    end
    chk("int_first_low", 32'(first_low), 32'd4);
    chk("int_low_len",   32'(low_cnt),   32'd100);
    chk("int_ovr_set",   32'(int_ovr),   32'h1);
    chk("int_n_end",     32'(int_n),     32'h1);

    // Reset during the low phase
    fire_gap(4'hE, 10);
    chk("int_wait_low", 32'(int_n), 32'h0);
    rstn = 1'b0;
    #1;
    chk("arst_int_n",    32'(int_n),         32'h1);
    chk("arst_req",      32'(req),           32'h0);
    chk("arst_fire_cnt", 32'(fire_cnt),      32'h0);
    chk("arst_int_ovr",  32'(int_ovr),       32'h0);
    chk("arst_cyc_min",  32'(cyc_min),       32'hFFFF);
    chk("arst_cyc_max",  32'(cyc_max),       32'h0);
    chk("arst_data",     lvds_data,          32'h0);
    chk("arst_period",   32'(dut.period_q),  32'hFFFF);
    chk("arst_state",    32'(dut.state_q),   32'(ST_IDLE));
    repeat (3) tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk("arst_int_n_after", 32'(int_n), 32'h1);

    // Clear coincident with a fire event: cleared, and that event is the first fire
    fire_gap(4'h1, 40);
    f_cmd = 4'h1;
    fire  = 1'b1;
    repeat (3) tick();
    fire = 1'b0;
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    repeat (2) tick();
    chk("clrw_min", 32'(cyc_min),  32'hFFFF);
    chk("clrw_max", 32'(cyc_max),  32'h0);
    chk("clrw_cnt", 32'(fire_cnt), 32'h0);
    repeat (19) tick();
    fire_gap(4'h1, 10);
    chk("clrw_next_min", 32'(cyc_min),  32'd25);
    chk("clrw_next_max", 32'(cyc_max),  32'd25);
    chk("clrw_next_cnt", 32'(fire_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lvds_cmd_ctrl.md
LVDS_CMD_CTRL -- requirements
Module: lvds_cmd_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2: number of parallel LVDS data lanes.
REQ-002 Parameter DATA_W, default 16: bits per lane.
REQ-003 Parameter CYC_W, default 16: width of the fire-period counter and statistics.
REQ-004 Parameter INT_LEN, default 100: interrupt low time in clk cycles (range 2..255).
REQ-005 Parameter SYNC_STG, default 2: synchronizer depth on d_sck, fire and f_cmd (minimum 2).
REQ-006 Ports SHALL be, clock and reset first:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- prn_data  in  NUM_CH*DATA_W  lane data, lane 0 in the LSBs
- d_sck  in  1  mainboard data strobe
- fire  in  1  fire pulse from the mainboard
- f_cmd  in  4  motion/print command code
- clr_stats  in  1  synchronous clear of statistics and sticky flags
- lvds_valid  out  1  one-cycle data-valid strobe
- lvds_data  out  NUM_CH*DATA_W  captured lane data
- req  out  9  one-hot command request pulse
- cmd_err  out  1  sticky flag: unknown command seen at fire
- fire_cnt  out  CYC_W  count of fire events, saturating
- cyc_min  out  CYC_W  minimum measured fire period
- cyc_max  out  CYC_W  maximum measured fire period
- int_n  out  1  wave-update interrupt, active-low
- int_ovr  out  1  sticky flag: pass-end seen while the interrupt is busy
- data_switch  out  1  synchronized fire level

Function
REQ-007 d_sck, fire and f_cmd SHALL pass through SYNC_STG flops; prn_data SHALL be delayed by SYNC_STG flops so it stays aligned with d_sck.
REQ-008 A falling edge of synchronized d_sck SHALL load lvds_data with the aligned data and pulse lvds_valid high for exactly 1 cycle, registered one cycle after edge detection.
REQ-009 fire_evt is the rising edge of synchronized fire. fire held high SHALL produce only one event.
REQ-010 On fire_evt, the synchronized f_cmd SHALL be decoded. The request pulses one cycle later, high for 1 cycle:
- 0xA: req[0] prefill
- 0x1: req[1] up
- 0x2: req[2] down
- 0x3: req[3] shake-before-up
- 0x4: req[4] print
- 0x5: req[5] shake-before-down
- 0x6: req[6] shake-before pass
- 0x9: req[7] shake-bottom pass
- 0xE: req[8] pass-end
REQ-011 Any other code at fire_evt SHALL leave req all-zero and set cmd_err.
REQ-012 Total latency from fire first sampled high at clk to the req pulse SHALL be SYNC_STG+1 cycles.
REQ-013 The period counter SHALL clear to 0 on fire_evt, otherwise increment, and saturate at all-ones.
REQ-014 On fire_evt, when at least one earlier fire_evt has occurred since reset/clear and the counter is not saturated:
- cyc_min SHALL update to the counter value if it is smaller.
- cyc_max SHALL update to the counter value if it is larger.
REQ-015 The first fire_evt after reset/clear SHALL NOT update cyc_min or cyc_max.
REQ-016 Statistics outputs SHALL be registered one cycle after the internal update.
REQ-017 fire_cnt SHALL increment on each fire_evt and saturate at all-ones.
REQ-018 The interrupt FSM SHALL have states IDLE, WAIT and HOLD:
- IDLE to WAIT on a req[8] pulse.
- WAIT to HOLD after INT_LEN cycles counted in WAIT.
- HOLD to IDLE after 1 cycle.
REQ-019 int_n SHALL be 0 only in WAIT, i.e. exactly INT_LEN cycles low per pass-end.
REQ-020 A req[8] pulse in WAIT or HOLD SHALL be dropped and SHALL set int_ovr.
REQ-021 clr_stats SHALL have these effects in the cycle it is asserted:
- cyc_min to all-ones, cyc_max to 0, fire_cnt to 0.
- cmd_err and int_ovr cleared; the first-fire qualifier cleared.
- No effect on the FSM or the data path.
REQ-022 When clr_stats and fire_evt coincide, clear SHALL win and the event SHALL count as the first fire.
REQ-023 data_switch SHALL equal the last synchronizer stage of fire.

Reset
REQ-024 Asynchronous rstn low SHALL force all flops, including synchronizers and the FSM counter, to these values:
- lvds_valid=0, lvds_data=0, req=0
- cmd_err=0, int_ovr=0, fire_cnt=0
- cyc_min=all-ones, cyc_max=0
- period counter=all-ones
- int_n=1, FSM=IDLE
REQ-025 Reset asserted mid-interrupt SHALL return int_n to 1 immediately. No pending request SHALL survive reset.

Structure
REQ-026 Command code constants, request bit indices and FSM state encodings SHALL live in shared package lvds_pkg.
REQ-027 The synchronizer SHALL be the single sub-module sync_bus, parametrised in width and depth and instantiated for the control and data paths.

Verification
REQ-028 d_sck pulses low for 3 cycles with prn_data=0x1234_ABCD (NUM_CH=2) -> one lvds_valid pulse, lvds_data=0x1234ABCD, SYNC_STG+2 cycles after the falling edge.
REQ-029 fire rise with f_cmd=0x4, then f_cmd=0x7 -> first gives req=0x010 at SYNC_STG+1 cycles; second gives req=0 and cmd_err=1.
REQ-030 fires 50, 30 and 80 cycles apart -> cyc_min=30, cyc_max=80, fire_cnt=4.
REQ-031 pass-end fire -> int_n low for exactly 100 cycles; a second pass-end 20 cycles later leaves int_n unchanged and sets int_ovr=1.
REQ-032 No fire for 70000 cycles then fire -> period counter held at 0xFFFF, cyc_min and cyc_max unchanged.
REQ-033 rstn low during WAIT; clr_stats coincident with fire_evt -> int_n=1 and all reset values from REQ-024; clear-wins behaviour as in REQ-022.
